// File: rtl/tim_banked_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : tim_banked_wires                                             |
// | Description : Shared widths, bank port structs and parity helper for the   |
// |               banked dual-port TIM. The struct widths follow the default   |
// |               configuration below; overriding TIM_BANKS / TIM_DEPTH on     |
// |               the top also requires updating these two values.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tim_banked_wires;

  localparam int TIM_BANKS_CFG = 4;
  localparam int TIM_DEPTH_CFG = 1024;
  localparam int BW            = $clog2(TIM_BANKS_CFG);
  localparam int DW            = $clog2(TIM_DEPTH_CFG);

  // One bank request: byte write enables (all zero = read), word index, data, parity
  typedef struct packed {
    logic [3:0]    wen;
    logic [DW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wpar;
  } bank_in_type;

  // One bank response: registered read word plus its stored parity bits
  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rpar;
  } bank_out_type;

  typedef bank_in_type  bank_in_vector  [TIM_BANKS_CFG];
  typedef bank_out_type bank_out_vector [TIM_BANKS_CFG];

  // Even parity per byte: bit set when the byte holds an odd number of ones
  function automatic logic [3:0] byte_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tim_banked_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tim_bank                                                     |
// | Description : One single-port byte-write RAM bank with a registered read.  |
// |               Parity storage is present only with TIM_BANKED_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tim_bank
  import tim_banked_wires::*;
#(
  parameter int DEPTH = TIM_DEPTH_CFG
) (
  input  logic         clock,
  input  bank_in_type  bank_i,
  output bank_out_type bank_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-strobed write; read word registered every cycle (returns old data on a same-edge write)
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_i.wen[b]) begin
        mem_q[bank_i.addr][8*b +: 8] <= bank_i.wdata[8*b +: 8];
      end
    end
    rdata_q <= mem_q[bank_i.addr];
  end

  assign bank_o.rdata = rdata_q;

`ifdef TIM_BANKED_PARITY_EN
  logic [3:0] par_q [DEPTH];
  logic [3:0] rpar_q;

  // Parity bits follow the same byte strobes as the data they protect
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_i.wen[b]) begin
        par_q[bank_i.addr][b] <= bank_i.wpar[b];
      end
    end
    rpar_q <= par_q[bank_i.addr];
  end

  assign bank_o.rpar = rpar_q;
`else
  logic wpar_unused;
  assign wpar_unused = ^bank_i.wpar;
  assign bank_o.rpar = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: rtl/tim_banked.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tim_banked                                                   |
// | Description : Banked dual-port TIM. Instruction (read-only) and data ports |
// |               share word-interleaved banks; one cycle fixed latency; a     |
// |               same-bank conflict goes to D unless I was starved last time. |
// |               Optional per-byte parity: define TIM_BANKED_PARITY_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tim_banked
  import tim_banked_wires::*;
#(
  parameter int TIM_BANKS = TIM_BANKS_CFG,
  parameter int TIM_DEPTH = TIM_DEPTH_CFG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err
);

  localparam int IDX_HI = DW + BW + 1;

  logic [BW-1:0] i_bank, d_bank;
  logic [DW-1:0] i_idx, d_idx;
  logic          conflict, i_grant, d_grant;
  logic          starve_q, starve_d;

  logic          i_gnt_q, d_gnt_q, d_read_q;
  logic [BW-1:0] i_bank_q, d_bank_q;

  bank_in_type   bank_in  [TIM_BANKS];
  bank_out_type  bank_out [TIM_BANKS];

  assign i_bank = i_addr[BW+1:2];
  assign d_bank = d_addr[BW+1:2];
  assign i_idx  = i_addr[IDX_HI:BW+2];
  assign d_idx  = d_addr[IDX_HI:BW+2];

  // Byte offset and bits above the array wrap are don't-care
  logic addr_unused;
  assign addr_unused = ^{i_addr[31:IDX_HI+1], i_addr[1:0], d_addr[31:IDX_HI+1], d_addr[1:0]};

  // Requests arriving while reset is held are dropped, including their writes
  assign conflict = i_valid && d_valid && (i_bank == d_bank);
  assign d_grant  = reset && d_valid && !(conflict && starve_q);
  assign i_grant  = reset && i_valid && !(conflict && !starve_q);

  // Starvation flag: set when D beats I, cleared once I gets in or gives up
  always_comb begin
    starve_d = starve_q;
    if (conflict && d_grant) begin
      starve_d = 1'b1;
    end else if (i_grant || !i_valid) begin
      starve_d = 1'b0;
    end
  end

  // Steer each granted request onto its bank; at most one grant per bank
  always_comb begin
    for (int b = 0; b < TIM_BANKS; b++) begin
      bank_in[b] = '0;
      if (d_grant && (d_bank == BW'(b))) begin
        bank_in[b].addr  = d_idx;
        bank_in[b].wen   = d_wstrb;
        bank_in[b].wdata = d_wdata;
        bank_in[b].wpar  = byte_parity(d_wdata);
      end else if (i_grant && (i_bank == BW'(b))) begin
        bank_in[b].addr  = i_idx;
      end
    end
  end

  generate
    for (genvar g = 0; g < TIM_BANKS; g++) begin : g_bank
      tim_bank #(
        .DEPTH (TIM_DEPTH)
      ) u_bank (
        .clock  (clock),
        .bank_i (bank_in[g]),
        .bank_o (bank_out[g])
      );
    end
  endgenerate

  // Response bookkeeping: remember who was granted which bank for the T+1 steering
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= 1'b0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      d_read_q <= 1'b0;
      i_bank_q <= '0;
      d_bank_q <= '0;
    end else begin
      starve_q <= starve_d;
      i_gnt_q  <= i_grant;
      d_gnt_q  <= d_grant;
      d_read_q <= (d_wstrb == 4'b0000);
      i_bank_q <= i_bank;
      d_bank_q <= d_bank;
    end
  end

  assign i_ready = i_gnt_q;
  assign d_ready = d_gnt_q;
  assign i_rdata = i_gnt_q ? bank_out[i_bank_q].rdata : 32'h0;
  assign d_rdata = (d_gnt_q && d_read_q) ? bank_out[d_bank_q].rdata : 32'h0;

`ifdef TIM_BANKED_PARITY_EN
  assign i_err = i_gnt_q &&
                 (byte_parity(bank_out[i_bank_q].rdata) != bank_out[i_bank_q].rpar);
  assign d_err = d_gnt_q && d_read_q &&
                 (byte_parity(bank_out[d_bank_q].rdata) != bank_out[d_bank_q].rpar);
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif

endmodule
`default_nettype wire
